axi_lite_txn_scheduler: RTL

AXI_LITE_TXN_SCHEDULER -- requirements
Module: axi_lite_txn_scheduler

---
 rtl/axi_lite_txn_scheduler.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_txn_scheduler
// Description : Round-robin AXI-Lite master scheduler with independent write
//               and read paths, each guarded by a no-progress watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_txn_scheduler #(
    parameter  int NUM_MASTERS    = 2,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDXW           = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] aw_req,
    input  logic [NUM_MASTERS-1:0] ar_req,
    input  logic                   aw_hs,
    input  logic                   w_hs,
    input  logic                   b_hs,
    input  logic                   ar_hs,
    input  logic                   r_hs,
    output logic [NUM_MASTERS-1:0] wr_gnt,
    output logic [IDXW-1:0]        wr_gnt_idx,
    output logic                   wr_gnt_valid,
    output logic [NUM_MASTERS-1:0] rd_gnt,
    output logic [IDXW-1:0]        rd_gnt_idx,
    output logic                   rd_gnt_valid,
    output logic                   wr_timeout,
    output logic                   rd_timeout
);

    localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNTW-1:0] c_TO_MAX =
        CNTW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [NUM_MASTERS-1:0] c_ONE = NUM_MASTERS'(1);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_ADDR_DATA = 2'd1;
    localparam logic [1:0] W_RESP      = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // First requester found scanning upward from ptr, wrapping past the top.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [IDXW-1:0]        ptr);
        logic [IDXW-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[IDXW'(idx)]) begin
                pick  = IDXW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx);
        return (idx == IDXW'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Watchdog step: clear on progress, otherwise count up and stick at the limit.
    function automatic logic [CNTW-1:0] to_step(input logic [CNTW-1:0] cnt,
                                                input logic            progress);
        if (TIMEOUT_CYCLES == 0 || progress) begin
            return '0;
        end
        if (cnt == c_TO_MAX) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    logic [1:0]             r_wr_state;
    logic [IDXW-1:0]        r_wr_ptr;
    logic [NUM_MASTERS-1:0] r_wr_gnt;
    logic [IDXW-1:0]        r_wr_idx;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic [CNTW-1:0]        r_wr_cnt;
    logic                   r_wr_timeout;

    logic [IDXW-1:0] w_wr_pick;
    logic            w_aw_acc;
    logic            w_w_acc;
    logic            w_wr_progress;
    logic            w_wr_expire;

    always_comb begin
        w_wr_pick     = rr_pick(aw_req, r_wr_ptr);
        w_aw_acc      = aw_hs & ~r_aw_done;
        w_w_acc       = w_hs & ~r_w_done;
        w_wr_progress = 1'b0;
        if (r_wr_state == W_ADDR_DATA) begin
            w_wr_progress = w_aw_acc | w_w_acc;
        end else if (r_wr_state == W_RESP) begin
            w_wr_progress = b_hs;
        end
        w_wr_expire = (TIMEOUT_CYCLES != 0) && (r_wr_state != W_IDLE) &&
                      !w_wr_progress && (r_wr_cnt == c_TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_wr_ptr     <= '0;
            r_wr_gnt     <= '0;
            r_wr_idx     <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_wr_cnt     <= '0;
            r_wr_timeout <= 1'b0;
        end else begin
            r_wr_timeout <= 1'b0;
            if (w_wr_expire) begin
                // Abort leaves the pointer where arbitration put it.
                r_wr_state   <= W_IDLE;
                r_wr_gnt     <= '0;
                r_wr_idx     <= '0;
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
                r_wr_cnt     <= '0;
                r_wr_timeout <= 1'b1;
            end else begin
                case (r_wr_state)
                    W_IDLE: begin
                        if (|aw_req) begin
                            r_wr_state <= W_ADDR_DATA;
                            r_wr_gnt   <= c_ONE << w_wr_pick;
                            r_wr_idx   <= w_wr_pick;
                            r_wr_ptr   <= rr_next(w_wr_pick);
                            r_aw_done  <= 1'b0;
                            r_w_done   <= 1'b0;
                            r_wr_cnt   <= '0;
                        end
                    end
                    W_ADDR_DATA: begin
                        r_aw_done <= r_aw_done | aw_hs;
                        r_w_done  <= r_w_done | w_hs;
                        r_wr_cnt  <= to_step(r_wr_cnt, w_wr_progress);
                        if ((r_aw_done | aw_hs) && (r_w_done | w_hs)) begin
                            r_wr_state <= W_RESP;
                            r_wr_cnt   <= '0;
                        end
                    end
                    W_RESP: begin
                        r_wr_cnt <= to_step(r_wr_cnt, w_wr_progress);
                        if (b_hs) begin
                            r_wr_state <= W_IDLE;
                            r_wr_gnt   <= '0;
                            r_wr_idx   <= '0;
                            r_aw_done  <= 1'b0;
                            r_w_done   <= 1'b0;
                            r_wr_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_wr_state <= W_IDLE;
                        r_wr_gnt   <= '0;
                        r_wr_idx   <= '0;
                        r_wr_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [1:0]             r_rd_state;
    logic [IDXW-1:0]        r_rd_ptr;
    logic [NUM_MASTERS-1:0] r_rd_gnt;
    logic [IDXW-1:0]        r_rd_idx;
    logic [CNTW-1:0]        r_rd_cnt;
    logic                   r_rd_timeout;

    logic [IDXW-1:0] w_rd_pick;
    logic            w_rd_progress;
    logic            w_rd_expire;

    always_comb begin
        w_rd_pick     = rr_pick(ar_req, r_rd_ptr);
        w_rd_progress = 1'b0;
        if (r_rd_state == R_ADDR) begin
            w_rd_progress = ar_hs;
        end else if (r_rd_state == R_DATA) begin
            w_rd_progress = r_hs;
        end
        w_rd_expire = (TIMEOUT_CYCLES != 0) && (r_rd_state != R_IDLE) &&
                      !w_rd_progress && (r_rd_cnt == c_TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state   <= R_IDLE;
            r_rd_ptr     <= '0;
            r_rd_gnt     <= '0;
            r_rd_idx     <= '0;
            r_rd_cnt     <= '0;
            r_rd_timeout <= 1'b0;
        end else begin
            r_rd_timeout <= 1'b0;
            if (w_rd_expire) begin
                r_rd_state   <= R_IDLE;
                r_rd_gnt     <= '0;
                r_rd_idx     <= '0;
                r_rd_cnt     <= '0;
                r_rd_timeout <= 1'b1;
            end else begin
                case (r_rd_state)
                    R_IDLE: begin
                        if (|ar_req) begin
                            r_rd_state <= R_ADDR;
                            r_rd_gnt   <= c_ONE << w_rd_pick;
                            r_rd_idx   <= w_rd_pick;
                            r_rd_ptr   <= rr_next(w_rd_pick);
                            r_rd_cnt   <= '0;
                        end
                    end
                    R_ADDR: begin
                        r_rd_cnt <= to_step(r_rd_cnt, w_rd_progress);
                        if (ar_hs) begin
                            r_rd_state <= R_DATA;
                        end
                    end
                    R_DATA: begin
                        r_rd_cnt <= to_step(r_rd_cnt, w_rd_progress);
                        if (r_hs) begin
                            r_rd_state <= R_IDLE;
                            r_rd_gnt   <= '0;
                            r_rd_idx   <= '0;
                        end
                    end
                    default: begin
                        r_rd_state <= R_IDLE;
                        r_rd_gnt   <= '0;
                        r_rd_idx   <= '0;
                        r_rd_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign wr_gnt       = r_wr_gnt;
    assign wr_gnt_idx   = r_wr_idx;
    assign wr_gnt_valid = (r_wr_state != W_IDLE);
    assign wr_timeout   = r_wr_timeout;
    assign rd_gnt       = r_rd_gnt;
    assign rd_gnt_idx   = r_rd_idx;
    assign rd_gnt_valid = (r_rd_state != R_IDLE);
    assign rd_timeout   = r_rd_timeout;

endmodule
`default_nettype wire
